trace_record_arbiter: RTL and testbench

//   Shares one waveform-trace record port among NSRC signal-change requesters.

---
 rtl/trace_record_arbiter_if.sv | 27 ++
 rtl/trace_record_arbiter.sv | 116 +++++++++++
 tb/tb_trace_record_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/trace_record_arbiter_if.sv
// Bundle shared by the trace arbiter and its environment: requester side and record-writer side.
interface trace_record_arbiter_if #(
  parameter int NSRC = 4,
  parameter int DW   = 8,
  parameter int TW   = 32,
  parameter int SW   = 2
);
  logic                 tick;
  logic [NSRC-1:0]      req;
  logic [NSRC*DW-1:0]   req_data;
  logic [NSRC-1:0]      req_ack;
  logic                 rec_valid;
  logic                 rec_ready;
  logic [SW-1:0]        rec_src;
  logic [DW-1:0]        rec_data;
  logic [TW-1:0]        rec_time;

  modport master (
    input  tick, req, req_data, rec_ready,
    output req_ack, rec_valid, rec_src, rec_data, rec_time
  );

  modport slave (
    output tick, req, req_data, rec_ready,
    input  req_ack, rec_valid, rec_src, rec_data, rec_time
  );
endinterface

// File: rtl/trace_record_arbiter.sv
// Round-robin arbiter feeding a one-entry timestamped trace record slot.
// Optional TRACE_DEDUP_EN: drop grants whose value matches the source's last emitted value.
//   state | meaning
//   EMPTY | slot free, rec_valid=0
//   FULL  | slot holds a record, rec_valid=1
module trace_record_arbiter #(
  parameter int NSRC = 4,
  parameter int DW   = 8,
  parameter int TW   = 32,
  parameter int SW   = 2
) (
  input logic                    clk,
  input logic                    reset,
  trace_record_arbiter_if.master bus
);
  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t   state, state_nxt;
  logic [TW-1:0] time_ctr;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] idx;
  logic          grant_vld;
  logic          can_load;
  logic          ack_any;
  logic          emit;
  logic          load;
  logic [DW-1:0] req_val [NSRC];
  logic [DW-1:0] grant_data;
  logic [SW-1:0] src_q;
  logic [DW-1:0] data_q;
  logic [TW-1:0] time_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_unpack
    assign req_val[i] = bus.req_data[i*DW +: DW];
  end

  // Search begins one past the last winner so every requester is reached within NSRC grants.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NSRC);
      if (!grant_vld && bus.req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_data  = req_val[grant_idx];
  assign can_load    = (state == EMPTY) || bus.rec_ready;
  assign ack_any     = grant_vld && can_load && !reset;
  assign bus.req_ack = ack_any ? (NSRC'(1) << grant_idx) : '0;
  assign load        = ack_any && emit;

`ifdef TRACE_DEDUP_EN
  logic [DW-1:0]   last_val [NSRC];
  logic [NSRC-1:0] seen;

  assign emit = !(seen[grant_idx] && (last_val[grant_idx] == grant_data));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen <= '0;
      for (int i = 0; i < NSRC; i++) last_val[i] <= '0;
    end else if (ack_any) begin
      seen[grant_idx]     <= 1'b1;
      last_val[grant_idx] <= grant_data;
    end
  end
`else
  assign emit = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (bus.rec_ready && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_ctr <= '0;
      rr_ptr   <= IW'(NSRC - 1);
      src_q    <= '0;
      data_q   <= '0;
      time_q   <= '0;
    end else begin
      if (bus.tick) time_ctr <= time_ctr + 1'b1;
      if (ack_any)  rr_ptr   <= grant_idx;
      // Timestamp is the counter value before this cycle's tick.
      if (load) begin
        src_q  <= SW'(grant_idx);
        data_q <= grant_data;
        time_q <= time_ctr;
      end
    end
  end

  assign bus.rec_valid = (state == FULL);
  assign bus.rec_src   = src_q;
  assign bus.rec_data  = data_q;
  assign bus.rec_time  = time_q;
endmodule

// File: tb/tb_trace_record_arbiter.sv
// Directed bench for trace_record_arbiter with a cycle-level reference model of the record slot.
module tb_trace_record_arbiter;
  localparam int NSRC = 4;
  localparam int DW   = 8;
  localparam int TW   = 4;
  localparam int SW   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  trace_record_arbiter_if #(.NSRC(NSRC), .DW(DW), .TW(TW), .SW(SW)) bus ();

  trace_record_arbiter #(.NSRC(NSRC), .DW(DW), .TW(TW), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the slot contents, time count, last winner and dedup memory.
  int m_time, m_ptr, m_src, m_data, m_rtime;
  bit m_full;
  bit m_seen [NSRC];
  int m_last [NSRC];
  bit log_en = 1'b0;
  int rec_log[$];

  task automatic model_reset();
    m_time = 0; m_ptr = NSRC - 1; m_full = 0;
    m_src = 0; m_data = 0; m_rtime = 0;
    for (int i = 0; i < NSRC; i++) begin
      m_seen[i] = 0;
      m_last[i] = 0;
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    int g;
    int d;
    bit ld;
    if (reset) model_reset();
    g = -1;
    if (!reset && (!m_full || bus.rec_ready))
      for (int k = 1; k <= NSRC; k++)
        if (g < 0 && bus.req[(m_ptr + k) % NSRC]) g = (m_ptr + k) % NSRC;
    chk("req_ack",   64'(bus.req_ack), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("rec_valid", 64'(bus.rec_valid), 64'(m_full));
    chk("rec_src",   64'(bus.rec_src),   64'(m_src));
    chk("rec_data",  64'(bus.rec_data),  64'(m_data));
    chk("rec_time",  64'(bus.rec_time),  64'(m_rtime));
    if (log_en && bus.rec_valid && bus.rec_ready) rec_log.push_back(int'(bus.rec_data));
    if (!reset) begin
      ld = (g >= 0);
      d  = 0;
      if (g >= 0) begin
        d = int'(bus.req_data[g*DW +: DW]);
`ifdef TRACE_DEDUP_EN
        if (m_seen[g] && m_last[g] == d) ld = 0;
        m_seen[g] = 1;
        m_last[g] = d;
`endif
        m_ptr = g;
      end
      if (ld) begin
        m_full = 1; m_src = g; m_data = d; m_rtime = m_time;
      end else if (bus.rec_ready) begin
        m_full = 0;
      end
      if (bus.tick) m_time = (m_time + 1) % (1 << TW);
    end
  end

  task automatic set_in(input logic [NSRC-1:0] r, input logic [NSRC*DW-1:0] d,
                        input logic rdy, input logic tk);
    bus.req = r; bus.req_data = d; bus.rec_ready = rdy; bus.tick = tk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int exp_log[$];
    set_in('0, '0, 1'b0, 1'b0);
    step();
    #1 chk("ack_in_reset", 64'(bus.req_ack), 64'd0);
    step();
    reset = 1'b0;
    chk("reset_valid", 64'(bus.rec_valid), 64'd0);
    chk("reset_time",  64'(bus.rec_time),  64'd0);

    // idle ticks, then first grant stamped with 10
    for (int k = 0; k < 10; k++) begin
      set_in('0, '0, 1'b0, 1'b1);
      step();
    end
    set_in(4'b0001, 32'h0000_0011, 1'b0, 1'b0);
    #1 chk("t1_ack", 64'(bus.req_ack), 64'h1);
    step();
    chk("t1_valid", 64'(bus.rec_valid), 64'd1);
    chk("t1_time",  64'(bus.rec_time),  64'd10);
    chk("t1_data",  64'(bus.rec_data),  64'h11);

    // all requesting, writer always ready: back-to-back round robin
    reset_pulse();
    set_in(4'b1111, 32'h2322_2120, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("t2_ack", 64'(bus.req_ack), 64'd1 << (k % 4));
      step();
      chk("t2_src",   64'(bus.rec_src),   64'(k % 4));
      chk("t2_data",  64'(bus.rec_data),  64'(8'h20 + k % 4));
      chk("t2_time",  64'(bus.rec_time),  64'(k));
      chk("t2_valid", 64'(bus.rec_valid), 64'd1);
    end

    // writer stalls: one grant, record held, then src2 on release
    reset_pulse();
    set_in(4'b0101, 32'h003C_001F, 1'b0, 1'b1);
    #1 chk("t3_ack0", 64'(bus.req_ack), 64'h1);
    step();
    set_in(4'b0100, 32'h003C_001F, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t3_noack", 64'(bus.req_ack), 64'h0);
      step();
      chk("t3_hold_src",  64'(bus.rec_src),  64'd0);
      chk("t3_hold_data", 64'(bus.rec_data), 64'h1F);
      chk("t3_hold_time", 64'(bus.rec_time), 64'd0);
    end
    set_in(4'b0100, 32'h003C_001F, 1'b1, 1'b0);
    #1 chk("t3_ack2", 64'(bus.req_ack), 64'h4);
    step();
    chk("t3_src2",  64'(bus.rec_src),  64'd2);
    chk("t3_time2", 64'(bus.rec_time), 64'd5);

    // timestamp wrap in a 4-bit counter
    reset_pulse();
    for (int k = 0; k < 15; k++) begin
      set_in('0, '0, 1'b1, 1'b1);
      step();
    end
    set_in(4'b0010, 32'h0000_3300, 1'b1, 1'b0);
    step();
    chk("t4_time15", 64'(bus.rec_time), 64'd15);
    chk("t4_src",    64'(bus.rec_src),  64'd1);
    set_in('0, '0, 1'b1, 1'b1);
    step();
    set_in(4'b0010, 32'h0000_3400, 1'b1, 1'b0);
    step();
    chk("t4_time0", 64'(bus.rec_time), 64'd0);
    chk("t4_data",  64'(bus.rec_data), 64'h34);

    // reset while a stalled record is held
    set_in('0, '0, 1'b0, 1'b0);
    step();
    chk("t5_full", 64'(bus.rec_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_valid", 64'(bus.rec_valid), 64'd0);
    chk("t5_src",   64'(bus.rec_src),   64'd0);
    chk("t5_data",  64'(bus.rec_data),  64'd0);
    step();
    reset = 1'b0;
    set_in(4'b1111, 32'h2322_2120, 1'b1, 1'b0);
    #1 chk("t5_first", 64'(bus.req_ack), 64'h1);
    step();
    chk("t5_src0", 64'(bus.rec_src), 64'd0);

    // repeated value from one source
    reset_pulse();
    log_en = 1'b1;
    set_in(4'b0010, 32'h0000_5A00, 1'b1, 1'b0);
    #1 chk("t6_ack_a", 64'(bus.req_ack), 64'h2);
    step();
    #1 chk("t6_ack_b", 64'(bus.req_ack), 64'h2);
    step();
    set_in(4'b0010, 32'h0000_A500, 1'b1, 1'b0);
    #1 chk("t6_ack_c", 64'(bus.req_ack), 64'h2);
    step();
    set_in('0, '0, 1'b1, 1'b0);
    step();
    step();
    log_en = 1'b0;
`ifdef TRACE_DEDUP_EN
    exp_log = '{32'h5A, 32'hA5};
`else
    exp_log = '{32'h5A, 32'h5A, 32'hA5};
`endif
    chk("t6_count", 64'(rec_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++)
      chk("t6_rec", (i < rec_log.size()) ? 64'(rec_log[i]) : 64'hFFFF, 64'(exp_log[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
